// File: rtl/ps2_host_tx_if.sv
// Host-side command handshake for the PS/2 host transmitter.
// The master modport is the command issuer, the slave modport is ps2_host_tx.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  busy,
    input  tx_done,
    input  tx_err
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output busy,
    output tx_done,
    output tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, 11-bit frame
// shifted out on device clock falls, acknowledge check and a line-idle timeout.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned SETUP_CYCLES   = 200,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic           clk,
  input  logic           rst,
  ps2_host_tx_if.slave   host,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);

  localparam int unsigned MAX_A   = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Pull-down request for frame position idx (1..8 data LSB first, 9 parity, 10 stop).
  function automatic logic frame_oe(input logic [3:0] idx, input logic [7:0] b, input logic par);
    logic oe;
    case (idx)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: oe = ~b[idx[2:0] - 3'd1];
      4'd9:    oe = ~par;
      default: oe = 1'b0;
    endcase
    return oe;
  endfunction

  state_t           state_r;
  logic [7:0]       byte_r;
  logic             par_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       bitcnt_r;
  logic             ack_ok_r;
  logic             clk_oe_r;
  logic             data_oe_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic             ready_r;

  logic clk_meta_r;
  logic clk_sync_r;
  logic clk_prev_r;
  logic data_meta_r;
  logic data_sync_r;
  logic fall_s;
  logic [3:0] next_bit_s;

  assign fall_s     = clk_prev_r & ~clk_sync_r;
  assign next_bit_s = bitcnt_r + 4'd1;

  // Two-flop synchronizers; reset to the idle-high line level so no false fall appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk_in;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data_in;
      data_sync_r <= data_meta_r;
    end
  end

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      byte_r    <= 8'h00;
      par_r     <= 1'b0;
      cnt_r     <= '0;
      bitcnt_r  <= 4'd0;
      ack_ok_r  <= 1'b0;
      clk_oe_r  <= 1'b0;
      data_oe_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          if (host.tx_valid && ready_r) begin
            byte_r   <= host.tx_data;
            par_r    <= odd_parity(host.tx_data);
            cnt_r    <= '0;
            bitcnt_r <= 4'd0;
            ack_ok_r <= 1'b0;
            clk_oe_r <= 1'b1;
            busy_r   <= 1'b1;
            ready_r  <= 1'b0;
            state_r  <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (cnt_r == INHIBIT_LAST) begin
            cnt_r     <= '0;
            data_oe_r <= 1'b1;
            state_r   <= ST_START;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_START: begin
          if (cnt_r == SETUP_LAST) begin
            cnt_r    <= '0;
            bitcnt_r <= 4'd0;
            clk_oe_r <= 1'b0;
            state_r  <= ST_SEND;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
          // Timeout takes priority over any device clock fall on the same cycle.
          if (cnt_r == TIMEOUT_LAST) begin
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            done_r    <= 1'b1;
            err_r     <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (state_r == ST_SEND) begin
              if (fall_s) begin
                bitcnt_r  <= next_bit_s;
                data_oe_r <= frame_oe(next_bit_s, byte_r, par_r);
                if (next_bit_s == 4'd10) begin
                  state_r <= ST_ACK;
                end
              end
            end else if (state_r == ST_ACK) begin
              if (fall_s) begin
                ack_ok_r <= ~data_sync_r;
                state_r  <= ST_WAIT_IDLE;
              end
            end else begin
              if (clk_sync_r && data_sync_r) begin
                done_r  <= 1'b1;
                err_r   <= ~ack_ok_r;
                state_r <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          busy_r    <= 1'b0;
          ready_r   <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe    = clk_oe_r;
  assign ps2_data_oe   = data_oe_r;
  assign host.tx_ready = ready_r;
  assign host.busy     = busy_r;
  assign host.tx_done  = done_r;
  assign host.tx_err   = err_r;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset or 0xF0 scan-code select.
- Sits beside KeyboardDecoder on the shared PS2_CLK/PS2_DATA inout pair. Top level drives each line low when its *_oe is 1, else 1'bz.
- Performs clock inhibit, request-to-send, 11-bit frame shift-out on device-generated clock edges, and device acknowledge check.
- Reports completion with a done/error pulse.

Parameters:
- INHIBIT_CYCLES, 12000: clk cycles PS2_CLK is held low before request (120 us at 100 MHz).
- SETUP_CYCLES, 200: clk cycles PS2_DATA and PS2_CLK are both held low before PS2_CLK is released.
- TIMEOUT_CYCLES, 2000000: maximum clk cycles from PS2_CLK release to line-idle (20 ms).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  command byte; sampled on accept.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; accept = tx_valid & tx_ready.
- ps2_clk_in  in  1  raw PS2_CLK level (asynchronous).
- ps2_data_in  in  1  raw PS2_DATA level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_data_oe  out  1  1 = pull PS2_DATA low.
- busy  out  1  high in every state except IDLE; top uses it to ignore decoder output.
- tx_done  out  1  one-cycle pulse at end of transaction.
- tx_err  out  1  valid with tx_done: 1 = no ack or timeout.

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_done=0, tx_err=0, tx_ready=1. State=IDLE, all counters 0.
- Reset mid-operation releases both lines on the next edge and produces no tx_done.
- Inputs pass through a 2-FF synchronizer. fall = prev_sclk & ~sclk on the synchronized clock.
- Falling edges are ignored outside SEND and ACK, including those caused by our own inhibit.
- All outputs are registered.
- Odd parity: par = ~^byte.
- IDLE:
  - Both oe = 0.
  - On accept: latch byte, compute par, clear counters, go to INHIBIT on the next cycle.
  - tx_valid while not in IDLE is ignored and not queued.
- INHIBIT: clk_oe=1, data_oe=0, for exactly INHIBIT_CYCLES cycles, then START.
- START: clk_oe=1, data_oe=1 (start bit 0), for exactly SETUP_CYCLES cycles, then SEND.
- SEND:
  - clk_oe=0. Timeout counter runs. bitcnt starts at 0; data_oe holds the start bit.
  - On each fall, bitcnt increments, then data_oe is set for the new bitcnt:
    - bitcnt 1..8: data_oe = ~byte[bitcnt-1] (LSB first).
    - bitcnt 9: data_oe = ~par.
    - bitcnt 10: data_oe = 0 (stop bit, line released); go to ACK.
- ACK:
  - On the next fall, sample synchronized data.
  - Data 0: ack_ok=1. Data 1: ack_ok=0.
  - Go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until synchronized clk=1 and data=1 on the same cycle.
  - Then pulse tx_done=1 for one cycle with tx_err=~ack_ok, and return to IDLE.
  - tx_ready=1 on the cycle after the tx_done pulse.
- Timeout:
  - Counter clears on entering SEND and increments every cycle in SEND, ACK and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES: both oe=0, tx_done=1 with tx_err=1, go to IDLE.
  - If timeout and a fall occur on the same cycle, timeout wins.
- tx_err is 0 whenever tx_done is 0.
- Width rule: cycle counters are sized by $clog2 of the largest parameter plus 1. bitcnt is 4 bits.

Test Plan:
- Common bench setup: INHIBIT_CYCLES=20, SETUP_CYCLES=4, TIMEOUT_CYCLES=3000.
- Device model clocks at 40-cycle period, samples data on rise, and drives ack low on edge 11.
- Send 0xED -> clk_oe high exactly 24 cycles, data_oe high from cycle 21.
  - Device captures 0 (start), bits 1,0,1,1,0,1,1,1, parity 1 (six ones → odd parity bit 1), stop 1.
  - tx_done=1 with tx_err=0; tx_ready returns to 1.
- Send 0x00 -> parity bit 1 and all data bits 0 captured; done with tx_err=0.
- Send 0xFF -> parity bit 1 and eight 1s captured; done with tx_err=0.
- Device never acks (data stays high on edge 11) -> tx_done with tx_err=1 after lines idle.
- Device never clocks after release -> exactly 3000 cycles after entering SEND: tx_done=1, tx_err=1, both oe=0, tx_ready=1 on the next cycle.
- Busy and reset cases:
  - tx_valid pulsed during SEND with 0x55 -> ignored; only the original byte is observed.
  - rst asserted at bitcnt=5 -> next cycle both oe=0, tx_ready=1, no tx_done.
  - A new send after reset completes normally.
